redirect_ctrl: RTL
==================

# redirect_ctrl

Front-end redirect and BTB-write controller. It arbitrates PC redirect requests from commit (exception/ertn), execute (branch mispredict) and fetch2 (BTB false-hit on a non-branch) into one request to fetch1, and drives the per-stage flush vector. It holds a redirect that fetch1 cannot take yet. It also shares the single BTB write port between execute updates and fetch2 invalidations through a small queue.

## Interface
Parameters:
- BTBQ_DEPTH, 2: BTB write queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmt_redir_valid / cmt_redir_pc  in  1/32  commit redirect (exception, ertn)
- ex_redir_valid / ex_redir_pc  in  1/32  execute branch mispredict
- if2_redir_valid / if2_redir_pc  in  1/32  fetch2 prediction-error redirect (pc+4)
- fetch1_rdy  in  1  fetch1 accepts a new PC this cycle
- redir_valid / redir_pc  out  1/32  PC write request to fetch1
- flush_if1, flush_if2, flush_id, flush_ex  out  1 each  stage flushes
- ex_btb_upd_valid / ex_btb_upd_pc / ex_btb_upd_target  in  1/32/32  BTB allocate/update
- if2_btb_inv_valid / if2_btb_inv_pc  in  1/32  BTB invalidate
- btb_wr_ready  in  1  BTB accepts a write this cycle
- btb_wr_valid / btb_wr_inv / btb_wr_pc / btb_wr_target  out  1/1/32/32  BTB write port (inv=1: invalidate, target ignored)

## Operation
- Priority: cmt > ex > if2. The winner is the source of this cycle's request.
- Flush vector, combinational in the request cycle:
  - cmt: all four stages
  - ex: if1, if2, id
  - if2: if1 only
- State machine IDLE/PENDING.
  - IDLE, request present, fetch1_rdy=1: redir_valid=1, redir_pc=winner pc. Stay IDLE.
  - IDLE, request present, fetch1_rdy=0: latch winner pc and source, go to PENDING.
  - PENDING: redir_valid=1 and redir_pc=pending pc. flush_if1 and flush_if2 are held high so no wrong-path fetch advances. Return to IDLE on the first cycle with fetch1_rdy=1.
  - PENDING, new request arrives: it replaces the pending entry unless its source is strictly lower priority than the pending source, in which case it is ignored. The flushes of an accepted new request are still asserted that cycle.
- BTB queue, FIFO:
  - Enqueue rules: an if2 invalidate is suppressed if cmt_redir_valid or ex_redir_valid is high in the same cycle (it is younger and squashed).
  - Both requests and ≥2 free entries: ex is enqueued first, then if2.
  - Both requests and 1 free entry: ex is enqueued, if2 is dropped.
  - Queue full: new requests are dropped. BTB writes are hints, so loss is legal.
  - Dequeue when btb_wr_valid & btb_wr_ready. Enqueue and dequeue in the same cycle on a full queue: the slot freed this cycle is not reusable until the next cycle.
  - A cmt redirect does not purge the queue.

## Timing
- Redirect is combinational pass-through (0 cycles) when fetch1_rdy=1. With fetch1_rdy=0 the PC is presented in every cycle until the accepting cycle.
- The BTB queue adds a minimum of 1 cycle: an entry enqueued at cycle N is visible on btb_wr_* at N+1.
- Reset values:
  - redir_valid=0, redir_pc=0, all flush_*=0
  - btb_wr_valid=0, btb_wr_pc=0, btb_wr_target=0, btb_wr_inv=0
  - state=IDLE, queue empty
- Reset asserted mid-PENDING drops the pending redirect. Reset mid-queue discards all entries.
- Pointers are log2(BTBQ_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.

## Structure
- Add to cpu_defs: `redir_src_e` {NONE, IF2, EX, CMT} (ordered so magnitude compare gives priority) and `btb_wr_req_t` {inv, pc, target}.
- Sub-module `btb_wr_fifo` holds the queue. Arbitration and the FSM stay in the top level.

## Test plan
- Simultaneous requests: cmt 0x1c000100, ex 0x1c000200, if2 0x1c000304, fetch1_rdy=1 → same cycle redir_pc=0x1c000100, all four flushes=1.
- fetch1_rdy=0 for 3 cycles with ex 0x1c000040 → redir_valid=1, pc=0x1c000040 for 4 cycles, flush_if1/if2 high throughout, IDLE after the accepting cycle.
- PENDING with ex source, then if2 0x1c000504 arrives → ignored. A later cmt 0x1c008000 arrives → redir_pc switches to 0x1c008000 and flush_ex=1 that cycle.
- Queue empty, ex update (0x1c000010→0x1c000080) and if2 invalidate 0x1c000020 in one cycle, btb_wr_ready=1 → ex entry out at N+1, invalidate at N+2.
- btb_wr_ready=0, 3 ex updates → first two are held in order, third dropped. Raise ready → exactly 2 writes.
- if2 invalidate in the same cycle as ex_redir_valid → never appears on btb_wr_*.

Source files
------------

// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the front-end redirect controller: redirect sources, FSM states
// and the BTB write request carried through the write queue.
package redirect_ctrl_pkg;

  // Ordered so that a plain magnitude compare gives redirect priority.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF2  = 2'd1,
    SRC_EX   = 2'd2,
    SRC_CMT  = 2'd3
  } redir_src_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } redir_state_e;

  typedef struct packed {
    logic        inv;
    logic [31:0] pc;
    logic [31:0] target;
  } btb_wr_req_t;

  localparam int BTB_REQ_W = $bits(btb_wr_req_t);

  // Returns {if1, if2, id, ex} flushes implied by a redirect from src.
  function automatic logic [3:0] flush_mask(input redir_src_e src);
    case (src)
      SRC_CMT: flush_mask = 4'b1111;
      SRC_EX:  flush_mask = 4'b1110;
      SRC_IF2: flush_mask = 4'b1000;
      default: flush_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/btb_wr_fifo.sv
// BTB write queue: up to two enqueues per cycle (push0 first), one dequeue per cycle.
// Free space is judged on the start-of-cycle occupancy, so a slot popped this cycle is reused next cycle.
module btb_wr_fifo
  import redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push0_valid,
  input  logic [BTB_REQ_W-1:0] i_push0_data,
  input  logic                 i_push1_valid,
  input  logic [BTB_REQ_W-1:0] i_push1_data,
  input  logic                 i_pop,
  output logic                 o_valid,
  output logic [BTB_REQ_W-1:0] o_data
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [BTB_REQ_W-1:0] r_mem [DEPTH];

  logic [PW-1:0] w_count;
  logic [PW-1:0] w_free;
  logic [PW-1:0] w_slot1;
  logic          w_empty;
  logic          w_full;
  logic          w_take0;
  logic          w_take1;
  logic          w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count = r_wptr - r_rptr;
  assign w_free  = PW'(DEPTH) - w_count;

  // push1 only gets in if a slot remains after push0 has been placed.
  assign w_take0 = i_push0_valid & ~w_full;
  assign w_take1 = i_push1_valid & (w_take0 ? (w_free >= PW'(2)) : ~w_full);
  assign w_slot1 = r_wptr + {{AW{1'b0}}, w_take0};
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_take0) r_mem[r_wptr[AW-1:0]] <= i_push0_data;
      if (w_take1) r_mem[w_slot1[AW-1:0]] <= i_push1_data;
      r_wptr <= r_wptr + PW'(w_take0) + PW'(w_take1);
      r_rptr <= r_rptr + PW'(w_pop);
    end
  end

  assign o_valid = ~w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect arbiter/holder (cmt > ex > if2) with stage flushes, plus the
// BTB write-port sharing between execute updates and fetch2 invalidations.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int BTBQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmt_redir_valid,
  input  logic [31:0] cmt_redir_pc,
  input  logic        ex_redir_valid,
  input  logic [31:0] ex_redir_pc,
  input  logic        if2_redir_valid,
  input  logic [31:0] if2_redir_pc,
  input  logic        fetch1_rdy,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        flush_if1,
  output logic        flush_if2,
  output logic        flush_id,
  output logic        flush_ex,
  input  logic        ex_btb_upd_valid,
  input  logic [31:0] ex_btb_upd_pc,
  input  logic [31:0] ex_btb_upd_target,
  input  logic        if2_btb_inv_valid,
  input  logic [31:0] if2_btb_inv_pc,
  input  logic        btb_wr_ready,
  output logic        btb_wr_valid,
  output logic        btb_wr_inv,
  output logic [31:0] btb_wr_pc,
  output logic [31:0] btb_wr_target
);

  redir_state_e r_state;
  logic [31:0]  r_pend_pc;
  redir_src_e   r_pend_src;

  redir_state_e w_state_nxt;
  logic [31:0]  w_pend_pc_nxt;
  redir_src_e   w_pend_src_nxt;
  redir_src_e   w_src;
  logic [31:0]  w_req_pc;
  logic         w_accept;
  logic [3:0]   w_flush;

  always_comb begin
    w_src    = SRC_NONE;
    w_req_pc = '0;
    if (cmt_redir_valid) begin
      w_src    = SRC_CMT;
      w_req_pc = cmt_redir_pc;
    end else if (ex_redir_valid) begin
      w_src    = SRC_EX;
      w_req_pc = ex_redir_pc;
    end else if (if2_redir_valid) begin
      w_src    = SRC_IF2;
      w_req_pc = if2_redir_pc;
    end
  end

  // While pending, an equal-or-higher priority request replaces the held one.
  assign w_accept = (w_src != SRC_NONE) && ((r_state == ST_IDLE) || (w_src >= r_pend_src));

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_pc_nxt  = r_pend_pc;
    w_pend_src_nxt = r_pend_src;
    redir_valid    = 1'b0;
    redir_pc       = '0;
    w_flush        = w_accept ? flush_mask(w_src) : 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          redir_valid = 1'b1;
          redir_pc    = w_req_pc;
          if (!fetch1_rdy) begin
            w_state_nxt    = ST_PENDING;
            w_pend_pc_nxt  = w_req_pc;
            w_pend_src_nxt = w_src;
          end
        end
      end
      ST_PENDING: begin
        redir_valid     = 1'b1;
        redir_pc        = w_accept ? w_req_pc : r_pend_pc;
        w_flush[3:2]    = 2'b11;
        if (fetch1_rdy) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
          w_pend_pc_nxt  = w_req_pc;
          w_pend_src_nxt = w_src;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pend_pc  <= '0;
      r_pend_src <= SRC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_pend_src <= w_pend_src_nxt;
    end
  end

  assign flush_if1 = w_flush[3];
  assign flush_if2 = w_flush[2];
  assign flush_id  = w_flush[1];
  assign flush_ex  = w_flush[0];

  // An invalidate is from a younger instruction that an older redirect squashes this cycle.
  logic                 w_inv_push;
  logic [BTB_REQ_W-1:0] w_upd_data;
  logic [BTB_REQ_W-1:0] w_inv_data;
  logic [BTB_REQ_W-1:0] w_head_data;
  btb_wr_req_t          w_head;

  assign w_inv_push = if2_btb_inv_valid & ~cmt_redir_valid & ~ex_redir_valid;
  assign w_upd_data = {1'b0, ex_btb_upd_pc, ex_btb_upd_target};
  assign w_inv_data = {1'b1, if2_btb_inv_pc, 32'h0};

  btb_wr_fifo #(.DEPTH(BTBQ_DEPTH)) u_btb_wr_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push0_valid (ex_btb_upd_valid),
    .i_push0_data  (w_upd_data),
    .i_push1_valid (w_inv_push),
    .i_push1_data  (w_inv_data),
    .i_pop         (btb_wr_valid & btb_wr_ready),
    .o_valid       (btb_wr_valid),
    .o_data        (w_head_data)
  );

  assign w_head        = w_head_data;
  assign btb_wr_inv    = w_head.inv;
  assign btb_wr_pc     = w_head.pc;
  assign btb_wr_target = w_head.target;

endmodule
